// File: rtl/fu_pkg.sv
// Shared definitions for the sequential add/subtract functional unit:
// controller state encoding, slice width and operation encoding.
package fu_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } fu_state_t;

    // Width of the time-shared adder slice
    localparam int unsigned NIB_W = 4;

    // Operation select carried on the sub input
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fu_seqadd_ctrl_if.sv
// Request/response bundle of the sequential add/subtract unit.
// master drives the request side, slave is the functional unit.
interface fu_seqadd_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport master (
        output start, sub, opa, opb,
        input  busy, done, result, carry_out, overflow, zero
    );

    modport slave (
        input  start, sub, opa, opb,
        output busy, done, result, carry_out, overflow, zero
    );
endinterface

// File: rtl/fu_seq_slice4.sv
// Purely combinational 4-bit carry-lookahead adder slice.
// ovf is the carry into the top bit XOR the carry out, so it gives the
// signed overflow when this slice handles the most significant nibble.
module fu_seq_slice4
    import fu_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout,
    output logic             ovf
);

    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] p;
    logic [NIB_W:0]   c;

    // Generate/propagate terms and fully expanded lookahead carries
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        s    = p ^ c[NIB_W-1:0];
        cout = c[NIB_W];
        ovf  = c[NIB_W-1] ^ c[NIB_W];
    end

endmodule

// File: rtl/fu_seqadd_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract unit. One 4-bit lookahead slice is
// reused across the operand, least significant nibble first, with a carry
// register linking consecutive nibbles. Subtraction is a + ~b + 1, the +1
// entering as the initial carry. WIDTH must be a multiple of 4 and >= 8.
module fu_seqadd_ctrl
    import fu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    fu_seqadd_ctrl_if.slave   bus
);

    localparam int unsigned NIB   = WIDTH / NIB_W;
    localparam int unsigned CNT_W = $clog2(NIB);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

    fu_state_t state_q;
    fu_state_t state_d;

    logic [NIB-1:0][NIB_W-1:0] a_q;
    logic [NIB-1:0][NIB_W-1:0] b_q;
    logic [NIB-1:0][NIB_W-1:0] res_q;
    logic [NIB-1:0][NIB_W-1:0] res_nx;
    logic [CNT_W-1:0]          cnt_q;
    logic                      carry_q;
    logic                      cout_q;
    logic                      ovf_q;
    logic                      zero_q;

    logic [NIB_W-1:0] slice_s;
    logic             slice_cout;
    logic             slice_ovf;

    logic accept;
    logic last;

    assign accept = (state_q != RUN) && bus.start;
    assign last   = (state_q == RUN) && (cnt_q == CNT_LAST);

    fu_seq_slice4 u_slice (
        .a    (a_q[cnt_q]),
        .b    (b_q[cnt_q]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout),
        .ovf  (slice_ovf)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE accepts a new start directly for back-to-back ops
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    state_d = bus.start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result with the current slice sum merged into the active nibble
    always_comb begin
        res_nx        = res_q;
        res_nx[cnt_q] = slice_s;
    end

    // Operand capture, per-nibble accumulation and completion flags
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.opa;
            b_q     <= (bus.sub == OP_SUB) ? ~bus.opb : bus.opb;
            carry_q <= bus.sub;
            cnt_q   <= '0;
            res_q   <= '0;
        end else if (state_q == RUN) begin
            res_q   <= res_nx;
            carry_q <= slice_cout;
            cnt_q   <= cnt_q + 1'b1;
            if (last) begin
                cout_q <= slice_cout;
                ovf_q  <= slice_ovf;
                zero_q <= (res_nx == '0);
            end
        end
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.result    = res_q;
    assign bus.carry_out = cout_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;

endmodule
